// File: rtl/ahb_lite_arbiter2_pkg.sv
// Shared AHB-Lite encodings and master identifiers for the two-master arbiter.
package ahb_lite_arbiter2_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } mst_e;

    function automatic logic [1:0] mst_onehot(input mst_e m);
        return (m == MST_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ahb_lite_arbiter2_if.sv
// One AHB-Lite link: initiator drives address/control/write data, target returns ready/resp/read data.
interface ahb_lite_arbiter2_if;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_arbiter2_mux.sv
// Combinational steering: address phase follows the grant, data phase follows the owner.
module ahb_lite_arb2_mux
    import ahb_lite_arbiter2_pkg::*;
(
    input  mst_e                 i_gnt,
    input  mst_e                 i_own,
    input  logic                 i_own_vld,
    ahb_lite_arbiter2_if.slave   m0,
    ahb_lite_arbiter2_if.slave   m1,
    ahb_lite_arbiter2_if.master  s
);
    logic w_sel1;
    logic w_own1;

    assign w_sel1 = (i_gnt == MST_1);
    assign w_own1 = (i_own == MST_1);

    assign s.HTRANS    = w_sel1 ? m1.HTRANS    : m0.HTRANS;
    assign s.HADDR     = w_sel1 ? m1.HADDR     : m0.HADDR;
    assign s.HWRITE    = w_sel1 ? m1.HWRITE    : m0.HWRITE;
    assign s.HSIZE     = w_sel1 ? m1.HSIZE     : m0.HSIZE;
    assign s.HBURST    = w_sel1 ? m1.HBURST    : m0.HBURST;
    assign s.HPROT     = w_sel1 ? m1.HPROT     : m0.HPROT;
    assign s.HMASTLOCK = w_sel1 ? m1.HMASTLOCK : m0.HMASTLOCK;

    assign s.HWDATA    = w_own1 ? m1.HWDATA : m0.HWDATA;

    // Only the master that owns a live data phase may see an ERROR.
    assign m0.HRESP    = (i_own_vld && !w_own1) ? s.HRESP : HRESP_OKAY;
    assign m1.HRESP    = (i_own_vld &&  w_own1) ? s.HRESP : HRESP_OKAY;
    assign m0.HRDATA   = s.HRDATA;
    assign m1.HRDATA   = s.HRDATA;
endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter; grant moves only on an unlocked IDLE from the granted master.
module ahb_lite_arbiter2
    import ahb_lite_arbiter2_pkg::*;
#(
    parameter bit PARK_MASTER = 1'b0,
    parameter bit ROUND_ROBIN = 1'b1
)(
    input  logic                 HCLK,
    input  logic                 HRESETN,
    ahb_lite_arbiter2_if.slave   m0,
    ahb_lite_arbiter2_if.slave   m1,
    ahb_lite_arbiter2_if.master  s,
    output logic                 S_HSEL,
    output logic                 S_HREADYIN,
    output logic [1:0]           GRANT
);
    localparam mst_e PARK = mst_e'(PARK_MASTER);

    mst_e r_gnt;
    mst_e r_own;
    logic r_own_vld;

    logic w_req0;
    logic w_req1;
    logic w_gnt_req;
    logic w_rel;
    mst_e w_gnt_next;

    assign w_req0    = m0.HTRANS[1];
    assign w_req1    = m1.HTRANS[1];
    assign w_gnt_req = (r_gnt == MST_1) ? w_req1 : w_req0;

    // BUSY and SEQ keep the grant; only an unlocked IDLE is a release point.
    assign w_rel = (r_gnt == MST_1)
                 ? (m1.HTRANS == HTRANS_IDLE) && !m1.HMASTLOCK
                 : (m0.HTRANS == HTRANS_IDLE) && !m0.HMASTLOCK;

    always_comb begin
        w_gnt_next = r_gnt;
        if (ROUND_ROBIN) begin
            if (r_gnt == MST_0 && w_req1)
                w_gnt_next = MST_1;
            else if (r_gnt == MST_1 && w_req0)
                w_gnt_next = MST_0;
        end else begin
            if (w_req0)
                w_gnt_next = MST_0;
            else if (w_req1)
                w_gnt_next = MST_1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_gnt     <= PARK;
            r_own     <= PARK;
            r_own_vld <= 1'b0;
        end else if (s.HREADY) begin
            r_own     <= r_gnt;
            r_own_vld <= w_gnt_req;
            if (w_rel)
                r_gnt <= w_gnt_next;
        end
    end

    // A non-granted requester is stalled so its address phase stays on its bus.
    assign m0.HREADY = (r_gnt == MST_0 || (r_own_vld && r_own == MST_0)) ? s.HREADY : ~w_req0;
    assign m1.HREADY = (r_gnt == MST_1 || (r_own_vld && r_own == MST_1)) ? s.HREADY : ~w_req1;

    assign S_HSEL     = 1'b1;
    assign S_HREADYIN = s.HREADY;
    assign GRANT      = mst_onehot(r_gnt);

    ahb_lite_arb2_mux u_mux (
        .i_gnt     (r_gnt),
        .i_own     (r_own),
        .i_own_vld (r_own_vld),
        .m0        (m0),
        .m1        (m1),
        .s         (s)
    );
endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Directed bench for the two-master AHB-Lite arbiter: grant switching, BUSY, locks, ERROR and reset.
module tb_ahb_lite_arbiter2;
    import ahb_lite_arbiter2_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        S_HSEL;
    logic        S_HREADYIN;
    logic [1:0]  GRANT;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_arbiter2_if m0_if ();
    ahb_lite_arbiter2_if m1_if ();
    ahb_lite_arbiter2_if s_if ();

    ahb_lite_arbiter2 #(.PARK_MASTER(1'b0), .ROUND_ROBIN(1'b1)) dut (
        .HCLK       (HCLK),
        .HRESETN    (HRESETN),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .S_HSEL     (S_HSEL),
        .S_HREADYIN (S_HREADYIN),
        .GRANT      (GRANT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] addr,
                       input logic wr, input logic lock, input logic [2:0] burst);
        if (m == 0) begin
            m0_if.HTRANS = tr; m0_if.HADDR = addr; m0_if.HWRITE = wr;
            m0_if.HMASTLOCK = lock; m0_if.HBURST = burst;
        end else begin
            m1_if.HTRANS = tr; m1_if.HADDR = addr; m1_if.HWRITE = wr;
            m1_if.HMASTLOCK = lock; m1_if.HBURST = burst;
        end
    endtask

    task automatic slv(input logic rdy, input logic resp, input logic [31:0] rdata);
        s_if.HREADY = rdy;
        s_if.HRESP  = resp;
        s_if.HRDATA = rdata;
    endtask

    initial begin
        HRESETN = 1'b0;
        drv(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        m0_if.HSIZE = 3'b010; m0_if.HPROT = 4'b0011; m0_if.HWDATA = 32'h0;
        m1_if.HSIZE = 3'b001; m1_if.HPROT = 4'b0001; m1_if.HWDATA = 32'h0;
        slv(1'b1, 1'b0, 32'h0);

        // reset state
        repeat (2) @(negedge HCLK);
        #1;
        check("rst_grant",   32'(GRANT), 32'h1);
        check("rst_m0_rdy",  32'(m0_if.HREADY), 32'h1);
        check("rst_m1_rdy",  32'(m1_if.HREADY), 32'h1);
        check("rst_htrans",  32'(s_if.HTRANS), 32'h0);
        check("rst_m0_resp", 32'(m0_if.HRESP), 32'h0);
        check("rst_m1_resp", 32'(m1_if.HRESP), 32'h0);
        check("rst_hsel",    32'(S_HSEL), 32'h1);
        $display("txn reset: grant=%b", GRANT);
        @(negedge HCLK); HRESETN = 1'b1;

        // M1 write while parked on M0
        @(negedge HCLK);
        drv(1, HTRANS_NONSEQ, 32'h1000_0004, 1'b1, 1'b0, 3'b000);
        #1;
        check("w1_m1_stall", 32'(m1_if.HREADY), 32'h0);
        check("w1_grant0",   32'(GRANT), 32'h1);
        check("w1_htrans0",  32'(s_if.HTRANS), 32'h0);
        @(negedge HCLK); #1;
        check("w1_grant1",   32'(GRANT), 32'h2);
        check("w1_m1_rdy",   32'(m1_if.HREADY), 32'h1);
        check("w1_haddr",    s_if.HADDR, 32'h1000_0004);
        check("w1_htrans",   32'(s_if.HTRANS), 32'(HTRANS_NONSEQ));
        check("w1_hsize",    32'(s_if.HSIZE), 32'h1);
        check("w1_hprot",    32'(s_if.HPROT), 32'h1);
        @(negedge HCLK);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        m1_if.HWDATA = 32'hA5A5_0001;
        #1;
        check("w1_hwdata",   s_if.HWDATA, 32'hA5A5_0001);
        check("w1_done",     32'(m1_if.HREADY), 32'h1);
        $display("txn m1 write 0x10000004: grant=%b", GRANT);

        // M0 INCR4 read with a BUSY beat, M1 requesting
        @(negedge HCLK);
        drv(0, HTRANS_NONSEQ, 32'h1000_0000, 1'b0, 1'b0, 3'b011);
        #1;
        check("b_m0_stall",  32'(m0_if.HREADY), 32'h0);
        @(negedge HCLK);
        drv(1, HTRANS_NONSEQ, 32'h1000_0010, 1'b1, 1'b0, 3'b000);
        #1;
        check("b_grant_m0",  32'(GRANT), 32'h1);
        check("b_m0_rdy",    32'(m0_if.HREADY), 32'h1);
        check("b_m1_stall",  32'(m1_if.HREADY), 32'h0);
        check("b_hburst",    32'(s_if.HBURST), 32'h3);
        @(negedge HCLK);
        drv(0, HTRANS_BUSY, 32'h1000_0004, 1'b0, 1'b0, 3'b011);
        slv(1'b1, 1'b0, 32'h1111_0000);
        #1;
        check("b_busy_grant", 32'(GRANT), 32'h1);
        check("b_busy_htr",   32'(s_if.HTRANS), 32'(HTRANS_BUSY));
        check("b_m0_rdata",   m0_if.HRDATA, 32'h1111_0000);
        check("b_busy_m1",    32'(m1_if.HREADY), 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge HCLK);
            drv(0, HTRANS_SEQ, 32'h1000_0000 + 32'(4 * i), 1'b0, 1'b0, 3'b011);
            #1;
            check("b_seq_grant", 32'(GRANT), 32'h1);
        end
        @(negedge HCLK);
        drv(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        #1;
        check("b_idle_grant", 32'(GRANT), 32'h1);
        check("b_idle_m1",    32'(m1_if.HREADY), 32'h0);
        @(negedge HCLK); #1;
        check("b_sw_grant",   32'(GRANT), 32'h2);
        check("b_sw_m1_rdy",  32'(m1_if.HREADY), 32'h1);
        check("b_sw_haddr",   s_if.HADDR, 32'h1000_0010);
        check("b_sw_hwrite",  32'(s_if.HWRITE), 32'h1);
        $display("txn m0 incr4 read with busy: grant=%b", GRANT);

        // M0 locked sequence while M1 requests
        @(negedge HCLK);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        m1_if.HWDATA = 32'hA5A5_0002;
        drv(0, HTRANS_NONSEQ, 32'h1000_0000, 1'b0, 1'b1, 3'b000);
        #1;
        check("l_m1_wdata",   s_if.HWDATA, 32'hA5A5_0002);
        @(negedge HCLK);
        drv(1, HTRANS_NONSEQ, 32'h1000_0020, 1'b0, 1'b0, 3'b000);
        #1;
        check("l_grant",      32'(GRANT), 32'h1);
        check("l_lock",       32'(s_if.HMASTLOCK), 32'h1);
        check("l_m1_stall0",  32'(m1_if.HREADY), 32'h0);
        @(negedge HCLK);
        drv(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b1, 3'b000);
        #1;
        check("l_idle_lk_m1", 32'(m1_if.HREADY), 32'h0);
        @(negedge HCLK);
        drv(0, HTRANS_NONSEQ, 32'h1000_0008, 1'b1, 1'b1, 3'b000);
        #1;
        check("l_hold_grant", 32'(GRANT), 32'h1);
        check("l_hold_m1",    32'(m1_if.HREADY), 32'h0);
        check("l_haddr",      s_if.HADDR, 32'h1000_0008);
        @(negedge HCLK);
        drv(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        m0_if.HWDATA = 32'h5A5A_0008;
        #1;
        check("l_unlk_m1",    32'(m1_if.HREADY), 32'h0);
        check("l_unlk_grant", 32'(GRANT), 32'h1);
        check("l_m0_wdata",   s_if.HWDATA, 32'h5A5A_0008);
        @(negedge HCLK); #1;
        check("l_rel_grant",  32'(GRANT), 32'h2);
        check("l_rel_m1",     32'(m1_if.HREADY), 32'h1);
        $display("txn m0 locked read/write: grant=%b", GRANT);

        // ERROR response to M1
        @(negedge HCLK);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        slv(1'b0, 1'b1, 32'h0);
        #1;
        check("e1_m1_resp",   32'(m1_if.HRESP), 32'h1);
        check("e1_m1_rdy",    32'(m1_if.HREADY), 32'h0);
        check("e1_m0_resp",   32'(m0_if.HRESP), 32'h0);
        check("e1_hreadyin",  32'(S_HREADYIN), 32'h0);
        @(negedge HCLK);
        slv(1'b1, 1'b1, 32'h0);
        #1;
        check("e2_m1_resp",   32'(m1_if.HRESP), 32'h1);
        check("e2_m1_rdy",    32'(m1_if.HREADY), 32'h1);
        check("e2_m0_resp",   32'(m0_if.HRESP), 32'h0);
        @(negedge HCLK);
        slv(1'b1, 1'b0, 32'h0);
        #1;
        check("e3_m1_resp",   32'(m1_if.HRESP), 32'h0);
        check("e3_grant",     32'(GRANT), 32'h2);
        $display("txn m1 error response: grant=%b", GRANT);

        // Asynchronous reset during an M1 wait state
        @(negedge HCLK);
        drv(1, HTRANS_NONSEQ, 32'h1000_0030, 1'b0, 1'b0, 3'b000);
        @(negedge HCLK);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
        slv(1'b0, 1'b1, 32'h0);
        #1;
        check("r_pre_m1_rdy", 32'(m1_if.HREADY), 32'h0);
        check("r_pre_m1_rsp", 32'(m1_if.HRESP), 32'h1);
        #1;
        HRESETN = 1'b0;
        #1;
        check("r_grant",      32'(GRANT), 32'h1);
        check("r_m1_resp",    32'(m1_if.HRESP), 32'h0);
        check("r_m1_rdy",     32'(m1_if.HREADY), 32'h1);
        @(negedge HCLK);
        HRESETN = 1'b1;
        slv(1'b1, 1'b0, 32'h0);
        @(negedge HCLK); #1;
        check("r_post_grant", 32'(GRANT), 32'h1);
        check("r_post_m1_rdy", 32'(m1_if.HREADY), 32'h1);
        check("r_post_m1_rsp", 32'(m1_if.HRESP), 32'h0);
        $display("txn reset mid wait state: grant=%b", GRANT);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
